recovery_controller: RTL and testbench
======================================

# recovery_controller

Sequential consumer of the dual-core lockstep comparator's mismatch output. On a disagreeing result it holds both cores in reset for a fixed window, releases them for re-execution and counts consecutive failures. It forwards agreed results downstream, and enters a sticky fatal state once the retry budget is exhausted. It sits between the comparator and the cores' reset pins / result sink in the fault-tolerant system top.

## Interface

Parameters:
- RESET_CYCLES, 4, cycles core reset is held per recovery; legal range ≥1
- MAX_RETRIES, 3, consecutive mismatches tolerated before fatal; 0 means the first mismatch is fatal
- DATA_WIDTH, 32, result width

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous, active-low reset
- result_valid_i  in  1  both cores present a result this cycle
- signal_i  in  1  comparator mismatch flag, qualified by result_valid_i
- data_i  in  DATA_WIDTH  comparator's agreed result
- core_rst_no  out  1  active-low reset to both cores, registered
- data_valid_o  out  1  one-cycle pulse: data_o holds a committed result
- data_o  out  DATA_WIDTH  last committed result, registered
- retry_count_o  out  $clog2(MAX_RETRIES+1)  consecutive-mismatch count
- error_count_o  out  16  total mismatches since reset, saturating at 16'hFFFF
- fatal_o  out  1  sticky unrecoverable-fault flag

## Operation

- States: RUN, HOLD, FATAL. Reset state is RUN.
- RUN:
  - Behaviour with no valid result: no result_valid_i → no action.
  - Agreeing result (result_valid_i=1, signal_i=0):
    - data_o ← data_i; data_valid_o pulses.
    - retry_count ← 0.
  - Mismatch (result_valid_i=1, signal_i=1):
    - error_count increments, saturating.
    - If retry_count == MAX_RETRIES → FATAL.
    - Otherwise retry_count increments, hold counter ← RESET_CYCLES-1, and the block enters HOLD.
- HOLD:
  - core_rst_no=0.
  - Hold counter decrements each cycle; at 0 → RUN.
  - result_valid_i, signal_i and data_i are ignored, because the cores are in reset.
- FATAL:
  - core_rst_no=0 and fatal_o=1 permanently.
  - All inputs are ignored.
  - Only rst_ni exits FATAL.
- signal_i is ignored when result_valid_i=0.
- retry_count clears only on an agreeing result or on rst_ni. It does not clear on entry to HOLD.
- data_o keeps its value between commits.

## Timing

- Reset values (async, on rst_ni=0):
  - state=RUN
  - core_rst_no=0, so the cores are held during system reset
  - data_o=0, data_valid_o=0
  - retry_count_o=0, error_count_o=0
  - fatal_o=0
- Reset release: core_rst_no rises at the first clk_i rising edge after rst_ni deasserts.
- Commit latency:
  - An agreeing result sampled at edge N gives data_o/data_valid_o valid after edge N.
  - data_valid_o is high for exactly one cycle.
- Recovery window:
  - A mismatch sampled at edge N drives core_rst_no low after edge N.
  - core_rst_no stays low for exactly RESET_CYCLES cycles and is high again after edge N+RESET_CYCLES.
- Fatal:
  - A mismatch at edge N with retry_count==MAX_RETRIES sets fatal_o=1 and core_rst_no=0 after edge N.
  - Both stay in that state until rst_ni.
- error_count_o and retry_count_o update on the same edge as the state transition.
- rst_ni asserted mid-HOLD or in FATAL: all state and outputs return to their reset values immediately (asynchronous reset).
- Back-to-back agreeing results on consecutive cycles: each one commits and data_valid_o stays high.

## Structure

- Shared package `ft_pkg`:
  - `rec_state_t` enum (RUN, HOLD, FATAL)
  - default RESET_CYCLES / MAX_RETRIES constants
- Single module. The hold counter and the saturating error counter are small enough to stay inline.
- No sub-module.

## Test plan

- Reset then agreeing result data_i=32'hDEADBEEF → data_o=32'hDEADBEEF, one-cycle data_valid_o, retry_count_o=0, core_rst_no=1 from the first edge after rst_ni.
- Single mismatch (RESET_CYCLES=4) → core_rst_no low for exactly 4 cycles, retry_count_o=1, error_count_o=1. A following agreeing result → retry_count_o=0, error_count_o stays 1.
- MAX_RETRIES=3, four consecutive mismatches each after recovery → fourth sets fatal_o=1, core_rst_no stuck 0. Further agreeing inputs produce no data_valid_o.
- result_valid_i pulsed with signal_i=1 during HOLD → ignored: window length unchanged, counts unchanged.
- rst_ni asserted on the 2nd HOLD cycle and in FATAL → all outputs return to reset values asynchronously, with no clock edge needed.
- signal_i=1 with result_valid_i=0 in RUN → no state change, core_rst_no stays 1.

Source files
------------

// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared types and defaults for the lockstep fault-tolerance blocks
package ft_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      FATAL = 2'd2
   } rec_state_t;

   localparam int DEF_RESET_CYCLES = 4;
   localparam int DEF_MAX_RETRIES  = 3;

endpackage

// File: rtl/recovery_controller.sv
// rtl/recovery_controller.sv - lockstep mismatch recovery: core reset window, retry budget, result commit
module recovery_controller
   import ft_pkg::*;
#(
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int MAX_RETRIES  = DEF_MAX_RETRIES,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  result_valid_i,
   input  logic                  signal_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  core_rst_no,
   output logic                  data_valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1)-1:0] retry_count_o,
   output logic [15:0]           error_count_o,
   output logic                  fatal_o
);

   // Widths are clamped to one bit so degenerate parameter values still elaborate.
   localparam int RCW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam int HCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   localparam logic [RCW-1:0] RETRY_LIMIT = RCW'(MAX_RETRIES);
   localparam logic [HCW-1:0] HOLD_LOAD   = HCW'(RESET_CYCLES - 1);

   rec_state_t            state_q, state_d;
   logic [HCW-1:0]        hold_q, hold_d;
   logic [RCW-1:0]        retry_q, retry_d;
   logic [15:0]           err_q, err_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  core_rst_q, core_rst_d;
   logic                  fatal_q, fatal_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= RUN;
         hold_q     <= '0;
         retry_q    <= '0;
         err_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         core_rst_q <= 1'b0;
         fatal_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         retry_q    <= retry_d;
         err_q      <= err_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         core_rst_q <= core_rst_d;
         fatal_q    <= fatal_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      retry_d = retry_q;
      err_d   = err_q;
      data_d  = data_q;
      valid_d = 1'b0;

      unique case (state_q)
         RUN: begin
            if (result_valid_i && !signal_i) begin
               data_d  = data_i;
               valid_d = 1'b1;
               retry_d = '0;
            end else if (result_valid_i && signal_i) begin
               if (err_q != 16'hFFFF) begin
                  err_d = err_q + 16'd1;
               end
               if (retry_q == RETRY_LIMIT) begin
                  state_d = FATAL;
               end else begin
                  retry_d = retry_q + RCW'(1);
                  hold_d  = HOLD_LOAD;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            // Cores are in reset here, so anything on the result inputs is stale.
            if (hold_q == '0) begin
               state_d = RUN;
            end else begin
               hold_d = hold_q - HCW'(1);
            end
         end
         FATAL: begin
            state_d = FATAL;
         end
         default: begin
            state_d = FATAL;
         end
      endcase

      // Registered from the next state so the core reset moves on the same edge as the FSM.
      core_rst_d = (state_d == RUN);
      fatal_d    = (state_d == FATAL);
   end

   assign core_rst_no   = core_rst_q;
   assign data_valid_o  = valid_q;
   assign data_o        = data_q;
   assign retry_count_o = retry_q;
   assign error_count_o = err_q;
   assign fatal_o       = fatal_q;

endmodule

// File: tb/tb_recovery_controller.sv
// tb/tb_recovery_controller.sv - directed self-checking bench for recovery_controller
module tb_recovery_controller;

   logic        clk_i;
   logic        rst_ni;
   logic        result_valid_i;
   logic        signal_i;
   logic [31:0] data_i;
   logic        core_rst_no;
   logic        data_valid_o;
   logic [31:0] data_o;
   logic [1:0]  retry_count_o;
   logic [15:0] error_count_o;
   logic        fatal_o;

   int n_checks = 0;
   int n_pass   = 0;
   int len;

   recovery_controller #(
      .RESET_CYCLES (4),
      .MAX_RETRIES  (3),
      .DATA_WIDTH   (32)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .result_valid_i (result_valid_i),
      .signal_i       (signal_i),
      .data_i         (data_i),
      .core_rst_no    (core_rst_no),
      .data_valid_o   (data_valid_o),
      .data_o         (data_o),
      .retry_count_o  (retry_count_o),
      .error_count_o  (error_count_o),
      .fatal_o        (fatal_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_core_rst"}, 32'(core_rst_no), 32'd0);
      check({tag, "_data"},     data_o, 32'd0);
      check({tag, "_valid"},    32'(data_valid_o), 32'd0);
      check({tag, "_retry"},    32'(retry_count_o), 32'd0);
      check({tag, "_err"},      32'(error_count_o), 32'd0);
      check({tag, "_fatal"},    32'(fatal_o), 32'd0);
   endtask

   // One mismatch sampled at the next edge; returns at the negedge after it.
   task automatic mismatch();
      result_valid_i = 1'b1;
      signal_i       = 1'b1;
      @(negedge clk_i);
      result_valid_i = 1'b0;
      signal_i       = 1'b0;
   endtask

   // Counts cycles with core_rst_no low, optionally injecting a mismatch in the 2nd one.
   task automatic measure_low(input bit inject, output int cycles);
      cycles = 0;
      while (core_rst_no == 1'b0 && cycles < 20) begin
         if (inject && cycles == 1) begin
            result_valid_i = 1'b1;
            signal_i       = 1'b1;
            data_i         = 32'hBAD0BAD0;
         end
         cycles++;
         @(negedge clk_i);
         result_valid_i = 1'b0;
         signal_i       = 1'b0;
      end
      if (cycles >= 20) check("hold_timeout", 32'(cycles), 32'd4);
   endtask

   initial begin
      rst_ni         = 1'b0;
      result_valid_i = 1'b0;
      signal_i       = 1'b0;
      data_i         = 32'd0;
      #12;
      check_reset_values("reset");

      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("release_core_rst", 32'(core_rst_no), 32'd1);

      result_valid_i = 1'b1;
      data_i         = 32'hDEADBEEF;
      @(negedge clk_i);
      result_valid_i = 1'b0;
      check("commit_data",  data_o, 32'hDEADBEEF);
      check("commit_valid", 32'(data_valid_o), 32'd1);
      check("commit_retry", 32'(retry_count_o), 32'd0);
      @(negedge clk_i);
      check("valid_one_cycle", 32'(data_valid_o), 32'd0);
      check("data_held",       data_o, 32'hDEADBEEF);

      signal_i = 1'b1;
      @(negedge clk_i);
      signal_i = 1'b0;
      check("unqual_core_rst", 32'(core_rst_no), 32'd1);
      check("unqual_err",      32'(error_count_o), 32'd0);

      mismatch();
      check("mm1_core_rst", 32'(core_rst_no), 32'd0);
      check("mm1_retry",    32'(retry_count_o), 32'd1);
      check("mm1_err",      32'(error_count_o), 32'd1);
      measure_low(1'b0, len);
      check("mm1_window", 32'(len), 32'd4);

      result_valid_i = 1'b1;
      data_i         = 32'h12345678;
      @(negedge clk_i);
      data_i = 32'h9ABCDEF0;
      check("b2b_valid0", 32'(data_valid_o), 32'd1);
      check("agree_retry", 32'(retry_count_o), 32'd0);
      check("agree_err",   32'(error_count_o), 32'd1);
      @(negedge clk_i);
      result_valid_i = 1'b0;
      check("b2b_valid1", 32'(data_valid_o), 32'd1);
      check("b2b_data",   data_o, 32'h9ABCDEF0);

      mismatch();
      measure_low(1'b1, len);
      check("inject_window", 32'(len), 32'd4);
      check("inject_retry",  32'(retry_count_o), 32'd1);
      check("inject_err",    32'(error_count_o), 32'd2);
      check("inject_data",   data_o, 32'h9ABCDEF0);

      mismatch();
      @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1 check_reset_values("hold_rst");
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("hold_rst_release", 32'(core_rst_no), 32'd1);

      for (int i = 1; i <= 3; i++) begin
         mismatch();
         check($sformatf("retry_cnt%0d", i), 32'(retry_count_o), 32'(i));
         measure_low(1'b0, len);
         check($sformatf("retry_win%0d", i), 32'(len), 32'd4);
      end
      mismatch();
      check("fatal_flag",     32'(fatal_o), 32'd1);
      check("fatal_core_rst", 32'(core_rst_no), 32'd0);
      check("fatal_err",      32'(error_count_o), 32'd4);
      check("fatal_retry",    32'(retry_count_o), 32'd3);

      result_valid_i = 1'b1;
      data_i         = 32'hAAAA5555;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check($sformatf("fatal_novalid%0d", i), 32'(data_valid_o), 32'd0);
      end
      result_valid_i = 1'b0;
      check("fatal_sticky",   32'(fatal_o), 32'd1);
      check("fatal_stuck",    32'(core_rst_no), 32'd0);
      check("fatal_data",     data_o, 32'd0);

      #2 rst_ni = 1'b0;
      #1 check_reset_values("fatal_rst");
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("fatal_rst_release", 32'(core_rst_no), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
